// File: rtl/frac_mult_seq_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : frac_mult_seq_if                                         |
// | Description : Request and register-file writeback signals of the       |
// |               sequential fractional multiplier.                        |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
interface frac_mult_seq_if #(
  parameter int N       = 8,
  parameter int ADDR_SZ = 5
);
  logic               start;
  logic [N-1:0]       a_data;
  logic [N-1:0]       b_data;
  logic [ADDR_SZ-1:0] dest;
  logic               busy;
  logic               wb_en;
  logic [ADDR_SZ-1:0] wb_addr;
  logic [N-1:0]       wb_data;

  // Controller / register-file side
  modport master (
    output start, a_data, b_data, dest,
    input  busy, wb_en, wb_addr, wb_data
  );

  // Multiplier side
  modport slave (
    input  start, a_data, b_data, dest,
    output busy, wb_en, wb_addr, wb_data
  );
endinterface
`default_nettype wire

// File: rtl/frac_mult_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : frac_mult_seq                                            |
// | Description : Multi-cycle signed Q1.(N-1) shift-add multiplier. Works  |
// |               on operand magnitudes, LSB first, one step per cycle,    |
// |               and writes the result back through the register-file     |
// |               write port.                                              |
// | Option      : FRAC_MULT_SAT_EN - saturate the (-1.0)*(-1.0) overflow   |
// |               instead of wrapping to -1.0.                             |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module frac_mult_seq #(
  parameter int N = 8,
  parameter int M = 32
) (
  input  wire               clk,
  input  wire               rst,
  frac_mult_seq_if.slave    bus
);

  localparam int ADDR_SZ = $clog2(M);
  localparam int CNT_W   = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [N-1:0]       a_mag_q, a_mag_d;
  logic [N-1:0]       b_mag_q, b_mag_d;
  logic               sign_q, sign_d;
  logic [ADDR_SZ-1:0] dest_q, dest_d;
  logic [2*N-1:0]     acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               busy_q, busy_d;
  logic               wb_en_q, wb_en_d;
  logic [ADDR_SZ-1:0] wb_addr_q, wb_addr_d;
  logic [N-1:0]       wb_data_q, wb_data_d;

  logic [2*N-1:0]     w_pp;
  logic [2*N-1:0]     w_acc_step;
  logic [2*N-1:0]     w_prod;
  logic [N-1:0]       w_result;
  logic               w_unused_bits;

  // Partial product for this step, the accumulated magnitude and the signed,
  // renormalised result as it will look after the final step.
  always_comb begin
    w_pp       = b_mag_q[count_q] ? ({{N{1'b0}}, a_mag_q} << count_q) : '0;
    w_acc_step = acc_q + w_pp;
    w_prod     = sign_q ? -w_acc_step : w_acc_step;
`ifdef FRAC_MULT_SAT_EN
    // Only (-1.0)*(-1.0) can reach here: clamp to the largest value of the sign
    if (w_prod[2*N-1] != w_prod[2*N-2]) begin
      w_result = sign_q ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    end else begin
      w_result = w_prod[2*N-2:N-1];
    end
`else
    w_result = w_prod[2*N-2:N-1];
`endif
  end

  // Bits dropped by the renormalising truncation
`ifdef FRAC_MULT_SAT_EN
  assign w_unused_bits = ^w_prod[N-2:0];
`else
  assign w_unused_bits = ^{w_prod[2*N-1], w_prod[N-2:0]};
`endif

  // Next-state and datapath decode; every register holds unless a state updates it
  always_comb begin
    state_d   = state_q;
    a_mag_d   = a_mag_q;
    b_mag_d   = b_mag_q;
    sign_d    = sign_q;
    dest_d    = dest_q;
    acc_d     = acc_q;
    count_d   = count_q;
    busy_d    = busy_q;
    wb_en_d   = 1'b0;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;

    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (bus.start) begin
          // -1.0 negates to itself, which reads correctly as an unsigned magnitude
          a_mag_d = bus.a_data[N-1] ? -bus.a_data : bus.a_data;
          b_mag_d = bus.b_data[N-1] ? -bus.b_data : bus.b_data;
          sign_d  = bus.a_data[N-1] ^ bus.b_data[N-1];
          dest_d  = bus.dest;
          acc_d   = '0;
          count_d = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        acc_d   = w_acc_step;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(N-1)) begin
          // Writeback outputs are loaded on the edge that enters WB
          wb_en_d   = 1'b1;
          wb_addr_d = dest_q;
          wb_data_d = w_result;
          state_d   = S_WB;
        end
      end

      S_WB: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operand, accumulator and output registers; reset aborts any operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_mag_q   <= '0;
      b_mag_q   <= '0;
      sign_q    <= 1'b0;
      dest_q    <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      busy_q    <= 1'b0;
      wb_en_q   <= 1'b0;
      wb_addr_q <= '0;
      wb_data_q <= '0;
    end else begin
      a_mag_q   <= a_mag_d;
      b_mag_q   <= b_mag_d;
      sign_q    <= sign_d;
      dest_q    <= dest_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      busy_q    <= busy_d;
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
    end
  end

  assign bus.busy    = busy_q;
  assign bus.wb_en   = wb_en_q;
  assign bus.wb_addr = wb_addr_q;
  assign bus.wb_data = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_frac_mult_seq.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module      : tb_frac_mult_seq                                         |
// | Description : Directed self-checking bench for frac_mult_seq (N=8,     |
// |               M=32) with a small register-file model on writeback.     |
// | Option      : FRAC_MULT_SAT_EN changes the expected overflow result.   |
// | Revision    : 1.0 - initial release                                    |
// +------------------------------------------------------------------------+
module tb_frac_mult_seq;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] regs [0:31];

  frac_mult_seq_if #(.N(8), .ADDR_SZ(5)) bus ();

  frac_mult_seq #(.N(8), .M(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Register-file model: register 0 is hard-wired to zero
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
    end else if (bus.wb_en && bus.wb_addr != 5'd0) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Issue one operation at a negedge and follow it until busy drops (bounded).
  // Operands are scrambled right after acceptance; with inject set, a second
  // start with 0x7F*0x7F is pulsed during cycle 3 of the operation.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [4:0] d,
                       input bit inject, output int busy_cyc, output int wb_cyc,
                       output int pulses, output logic [7:0] data, output logic [4:0] addr);
    busy_cyc = 0; wb_cyc = 0; pulses = 0; data = 8'h00; addr = 5'h00;
    bus.start = 1'b1; bus.a_data = a; bus.b_data = b; bus.dest = d;
    @(negedge clk);
    bus.start = 1'b0; bus.a_data = 8'h11; bus.b_data = 8'h22; bus.dest = 5'h1F;
    for (int c = 1; c <= 20; c++) begin
      if (bus.busy) busy_cyc++;
      if (bus.wb_en) begin
        pulses++; wb_cyc = c; data = bus.wb_data; addr = bus.wb_addr;
      end
      if (!bus.busy) break;
      if (inject && c == 3) begin
        bus.start = 1'b1; bus.a_data = 8'h7F; bus.b_data = 8'h7F; bus.dest = 5'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    bus.start = 1'b0; bus.a_data = 8'h00; bus.b_data = 8'h00; bus.dest = 5'd0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wb_en !== 1'b0)    begin errors++; $display("FAIL reset_wb_en got=%b exp=0", bus.wb_en); end
    checks++; if (bus.wb_addr !== 5'd0)  begin errors++; $display("FAIL reset_wb_addr got=%0d exp=0", bus.wb_addr); end
    checks++; if (bus.wb_data !== 8'h00) begin errors++; $display("FAIL reset_wb_data got=%h exp=00", bus.wb_data); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL idle_no_start_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_basic();
    int bc, wc, np; logic [7:0] dt; logic [4:0] ad;
    do_op(8'h40, 8'h40, 5'd5, 1'b0, bc, wc, np, dt, ad);
    checks++; if (bc !== 9)      begin errors++; $display("FAIL half_busy_cycles got=%0d exp=9", bc); end
    checks++; if (wc !== 9)      begin errors++; $display("FAIL half_wb_cycle got=%0d exp=9", wc); end
    checks++; if (np !== 1)      begin errors++; $display("FAIL half_pulses got=%0d exp=1", np); end
    checks++; if (ad !== 5'd5)   begin errors++; $display("FAIL half_wb_addr got=%0d exp=5", ad); end
    checks++; if (dt !== 8'h20)  begin errors++; $display("FAIL half_wb_data got=%h exp=20", dt); end
    checks++; if (bus.wb_data !== 8'h20) begin errors++; $display("FAIL half_hold_data got=%h exp=20", bus.wb_data); end
    checks++; if (bus.wb_en !== 1'b0)    begin errors++; $display("FAIL half_wb_en_idle got=%b exp=0", bus.wb_en); end
    checks++; if (regs[5] !== 8'h20)     begin errors++; $display("FAIL half_regfile got=%h exp=20", regs[5]); end
  endtask

  task automatic test_signed();
    int bc, wc, np; logic [7:0] dt; logic [4:0] ad;
    do_op(8'hC0, 8'h40, 5'd3, 1'b0, bc, wc, np, dt, ad);
    checks++; if (ad !== 5'd3)  begin errors++; $display("FAIL signed_wb_addr got=%0d exp=3", ad); end
    checks++; if (dt !== 8'hE0) begin errors++; $display("FAIL signed_wb_data got=%h exp=e0", dt); end
    // -0.5 * -0.75 = 0.375 -> 0x30
    do_op(8'hC0, 8'hA0, 5'd4, 1'b0, bc, wc, np, dt, ad);
    checks++; if (dt !== 8'h30) begin errors++; $display("FAIL negneg_wb_data got=%h exp=30", dt); end
    // 0.5 * -1/128 = -1/256 -> floors to -1/128 = 0xFF
    do_op(8'h40, 8'hFF, 5'd4, 1'b0, bc, wc, np, dt, ad);
    checks++; if (dt !== 8'hFF) begin errors++; $display("FAIL floor_wb_data got=%h exp=ff", dt); end
  endtask

  task automatic test_overflow();
    int bc, wc, np; logic [7:0] dt; logic [4:0] ad; logic [7:0] exp_d;
`ifdef FRAC_MULT_SAT_EN
    exp_d = 8'h7F;
`else
    exp_d = 8'h80;
`endif
    do_op(8'h80, 8'h80, 5'd6, 1'b0, bc, wc, np, dt, ad);
    checks++; if (dt !== exp_d) begin errors++; $display("FAIL ovf_wb_data got=%h exp=%h", dt, exp_d); end
    // -1.0 * 0.5 = -0.5, no overflow
    do_op(8'h80, 8'h40, 5'd6, 1'b0, bc, wc, np, dt, ad);
    checks++; if (dt !== 8'hC0) begin errors++; $display("FAIL neg_one_wb_data got=%h exp=c0", dt); end
  endtask

  task automatic test_back_to_back();
    int bc, wc, np; logic [7:0] dt; logic [4:0] ad;
    do_op(8'h40, 8'h40, 5'd5, 1'b1, bc, wc, np, dt, ad);
    checks++; if (np !== 1)     begin errors++; $display("FAIL b2b_pulses got=%0d exp=1", np); end
    checks++; if (dt !== 8'h20) begin errors++; $display("FAIL b2b_first_data got=%h exp=20", dt); end
    checks++; if (ad !== 5'd5)  begin errors++; $display("FAIL b2b_first_addr got=%0d exp=5", ad); end
    checks++; if (bc !== 9)     begin errors++; $display("FAIL b2b_busy_cycles got=%0d exp=9", bc); end
    // Start on the first idle edge
    do_op(8'h7F, 8'h7F, 5'd7, 1'b0, bc, wc, np, dt, ad);
    checks++; if (wc !== 9)     begin errors++; $display("FAIL b2b_second_wb_cycle got=%0d exp=9", wc); end
    checks++; if (dt !== 8'h7E) begin errors++; $display("FAIL b2b_second_data got=%h exp=7e", dt); end
    checks++; if (regs[7] !== 8'h7E) begin errors++; $display("FAIL b2b_regfile got=%h exp=7e", regs[7]); end
  endtask

  task automatic test_reset_mid_run();
    int bc, wc, np; logic [7:0] dt; logic [4:0] ad; int pulses_after;
    bus.start = 1'b1; bus.a_data = 8'h40; bus.b_data = 8'h40; bus.dest = 5'd9;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL rstrun_busy got=%b exp=0", bus.busy); end
    checks++; if (bus.wb_addr !== 5'd0)  begin errors++; $display("FAIL rstrun_wb_addr got=%0d exp=0", bus.wb_addr); end
    checks++; if (bus.wb_data !== 8'h00) begin errors++; $display("FAIL rstrun_wb_data got=%h exp=00", bus.wb_data); end
    @(negedge clk);
    rst = 1'b0;
    pulses_after = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.wb_en || bus.busy) pulses_after++;
    end
    checks++; if (pulses_after !== 0) begin errors++; $display("FAIL rstrun_no_wb got=%0d exp=0", pulses_after); end
    do_op(8'h40, 8'h40, 5'd9, 1'b0, bc, wc, np, dt, ad);
    checks++; if (dt !== 8'h20 || ad !== 5'd9) begin errors++; $display("FAIL rstrun_retry got=%h/%0d exp=20/9", dt, ad); end
  endtask

  task automatic test_dest_zero();
    int bc, wc, np; logic [7:0] dt; logic [4:0] ad;
    // Preload a non-zero result so the zero result is observable
    do_op(8'h40, 8'h40, 5'd2, 1'b0, bc, wc, np, dt, ad);
    do_op(8'h7F, 8'h01, 5'd0, 1'b0, bc, wc, np, dt, ad);
    checks++; if (np !== 1)     begin errors++; $display("FAIL dest0_pulses got=%0d exp=1", np); end
    checks++; if (ad !== 5'd0)  begin errors++; $display("FAIL dest0_wb_addr got=%0d exp=0", ad); end
    checks++; if (dt !== 8'h00) begin errors++; $display("FAIL dest0_wb_data got=%h exp=00", dt); end
    checks++; if (bc !== 9)     begin errors++; $display("FAIL dest0_busy_cycles got=%0d exp=9", bc); end
    // Zero operand still takes the full latency
    do_op(8'h00, 8'h55, 5'd8, 1'b0, bc, wc, np, dt, ad);
    checks++; if (wc !== 9 || dt !== 8'h00) begin errors++; $display("FAIL zero_op got=cyc%0d/%h exp=cyc9/00", wc, dt); end
  endtask

  initial begin
    bus.start = 1'b0; bus.a_data = 8'h00; bus.b_data = 8'h00; bus.dest = 5'd0;
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_back_to_back();
    test_reset_mid_run();
    test_dest_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
